// File: rtl/audio_sample_player.sv
// Streams unsigned 8-bit samples from a handshaked memory, one per 22 kHz tick, with optional looping.
// Define AUDIO_PWM_OUT_EN to add a 256-cycle PWM DAC on pwm_out; otherwise pwm_out is tied low.
module audio_sample_player #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_27MHz,
    input  logic              reset,
    input  logic              clk_22khz,
    input  logic              play,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              loop_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              pwm_out
);
    localparam logic [DATA_W-1:0] SILENCE = 8'h80;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_tick_d;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_next_sample;
    logic [DATA_W-1:0] r_sample_out;
    logic              r_sample_valid;
    logic              r_done;
    logic              r_underrun;

    logic w_tick;
    logic w_at_end;
    logic w_accept;
    logic w_capture;
    logic w_emit;
    logic w_finish;
    logic w_underrun_set;

    assign w_tick   = clk_22khz & ~r_tick_d;
    assign w_at_end = (r_addr == r_end);

    // stop wins over every other event, including a play in the same cycle
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_emit         = 1'b0;
        w_finish       = 1'b0;
        w_underrun_set = 1'b0;
        if (stop) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (play && (start_addr <= end_addr)) begin
                        w_accept     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    w_underrun_set = w_tick;
                    if (mem_ack) begin
                        w_capture    = 1'b1;
                        w_state_next = S_READY;
                    end
                end
                S_READY: begin
                    if (w_tick) begin
                        w_emit       = 1'b1;
                        w_state_next = (!w_at_end || loop_en) ? S_FETCH : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_tick) begin
                        w_finish     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_27MHz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_27MHz) begin
        if (reset) begin
            r_tick_d       <= 1'b0;
            r_addr         <= '0;
            r_start        <= '0;
            r_end          <= '0;
            r_next_sample  <= SILENCE;
            r_sample_out   <= SILENCE;
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_tick_d       <= clk_22khz;
            r_sample_valid <= w_emit;
            r_done         <= w_finish;
            if (stop || w_finish) begin
                r_sample_out <= SILENCE;
            end else if (w_emit) begin
                r_sample_out <= r_next_sample;
            end
            if (w_accept) begin
                r_start    <= start_addr;
                r_end      <= end_addr;
                r_addr     <= start_addr;
                r_underrun <= 1'b0;
            end else if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
            if (w_capture) begin
                r_next_sample <= mem_data;
            end
            // the last address never increments, so a range ending at the top cannot wrap
            if (w_emit) begin
                if (!w_at_end) begin
                    r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else if (loop_en) begin
                    r_addr <= r_start;
                end
            end
        end
    end

    assign mem_req      = (r_state == S_FETCH);
    assign mem_addr     = r_addr;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign underrun     = r_underrun;

`ifdef AUDIO_PWM_OUT_EN
    logic [7:0] r_pwm_cnt;
    logic       r_pwm_out;

    always_ff @(posedge clk_27MHz) begin
        if (reset) begin
            r_pwm_cnt <= 8'd0;
            r_pwm_out <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            r_pwm_out <= (r_pwm_cnt < r_sample_out);
        end
    end

    assign pwm_out = r_pwm_out;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_player.sv
// Self-checking bench for audio_sample_player: directed and randomized playback compared
// against a queue model built from the sample memory contents and the tick count.
`timescale 1ns/1ps
module tb_audio_sample_player;
    localparam int ADDR_W    = 16;
    localparam int TICK_HALF = 8;

    logic              clk_27MHz  = 1'b0;
    logic              reset      = 1'b1;
    logic              clk_22khz  = 1'b0;
    logic              play       = 1'b0;
    logic              stop       = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr   = '0;
    logic              loop_en    = 1'b0;
    logic              mem_ack    = 1'b0;
    logic [7:0]        mem_data   = 8'h00;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic              underrun;
    logic              pwm_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastRaiseCyc = 0;
    int ackDelay = 2;
    bit ackHold = 1'b0;
    bit forceAck = 1'b0;
    int waitCnt = 0;

    logic [7:0] memArr [0:255];
    logic [7:0] obsVal [$];
    int         obsLat [$];
    int         doneCnt = 0;
    int         doneBadCnt = 0;
    logic [7:0] expQ [$];
    bit         expDone;

    audio_sample_player #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
        .clk_27MHz   (clk_27MHz),
        .reset       (reset),
        .clk_22khz   (clk_22khz),
        .play        (play),
        .stop        (stop),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .loop_en     (loop_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun),
        .pwm_out     (pwm_out)
    );

    initial forever #5 clk_27MHz = ~clk_27MHz;

    initial forever begin
        @(posedge clk_27MHz);
        cyc++;
    end

    // memory responder: acks ackDelay cycles after it first sees mem_req
    initial forever begin
        @(negedge clk_27MHz);
        if (forceAck) begin
            mem_ack  = 1'b1;
            mem_data = 8'h5A;
        end else if (ackHold) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else if (mem_req && !mem_ack) begin
            if (waitCnt >= ackDelay) begin
                mem_ack  = 1'b1;
                mem_data = memArr[mem_addr[7:0]];
                waitCnt  = 0;
            end else begin
                waitCnt++;
            end
        end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end
    end

    initial forever begin
        @(negedge clk_27MHz);
        if (sample_valid === 1'b1) begin
            obsVal.push_back(sample_out);
            obsLat.push_back(cyc - lastRaiseCyc);
        end
        if (done === 1'b1) begin
            doneCnt++;
            if (sample_out !== 8'h80) doneBadCnt++;
        end
    end

    // expected emitted samples for nTicks ticks after a play of [s..e]
    function automatic void modelPlayback(input int s, input int e, input bit lp, input int nTicks);
        int len = e - s + 1;
        int a;
        expQ.delete();
        expDone = 1'b0;
        for (int t = 0; t < nTicks; t++) begin
            if (!lp && t == len) begin
                expDone = 1'b1;
                break;
            end
            a = s + (t % len);
            expQ.push_back(memArr[a[7:0]]);
        end
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_27MHz);
    endtask

    task automatic tick();
        clk_22khz    = 1'b1;
        lastRaiseCyc = cyc;
        repeat (TICK_HALF) @(negedge clk_27MHz);
        clk_22khz = 1'b0;
        repeat (TICK_HALF) @(negedge clk_27MHz);
    endtask

    task automatic doPlay(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e, input logic lp);
        start_addr = s;
        end_addr   = e;
        loop_en    = lp;
        play       = 1'b1;
        @(negedge clk_27MHz);
        play = 1'b0;
    endtask

    task automatic doStop();
        stop = 1'b1;
        @(negedge clk_27MHz);
        stop = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (sample_out !== 8'h80) begin errors++; $display("[TB] FAIL reset_sample_out: got %h expected 80", sample_out); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sample_valid: got %b expected 0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm_out: got %b expected 0", pwm_out); end
        reset = 1'b0;
        cycles(2);
        tick();
        checks++; if (obsVal.size() !== 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_tick: got %0d samples busy %b expected 0 samples busy 0", obsVal.size(), busy); end
    endtask

    task automatic test_single_pass();
        int base = obsVal.size();
        int baseDone = doneCnt;
        ackDelay = 2;
        doPlay(16'h0010, 16'h0012, 1'b0);
        cycles(6);
        repeat (4) tick();
        modelPlayback(16'h0010, 16'h0012, 1'b0, 4);
        checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL single_count: got %0d expected %0d", obsVal.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
            checks++;
            if (obsVal[base + i] !== expQ[i] || obsLat[base + i] !== 1) begin
                errors++;
                $display("[TB] FAIL single_sample%0d: got %h latency %0d expected %h latency 1", i, obsVal[base + i], obsLat[base + i], expQ[i]);
            end
        end
        checks++; if (doneCnt - baseDone !== int'(expDone) || doneBadCnt !== 0) begin errors++; $display("[TB] FAIL single_done: got %0d (bad %0d) expected %0d", doneCnt - baseDone, doneBadCnt, int'(expDone)); end
        checks++; if (underrun !== 1'b0 || busy !== 1'b0 || sample_out !== 8'h80) begin errors++; $display("[TB] FAIL single_end: got underrun %b busy %b sample %h expected 0 0 80", underrun, busy, sample_out); end
    endtask

    task automatic test_loop();
        int base = obsVal.size();
        int baseDone = doneCnt;
        doPlay(16'h0010, 16'h0012, 1'b1);
        cycles(6);
        for (int t = 0; t < 7; t++) begin
            tick();
            if (t == 2) begin
                checks++; if (mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL loop_wrap_addr: got %h expected 0010", mem_addr); end
            end
        end
        modelPlayback(16'h0010, 16'h0012, 1'b1, 7);
        checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL loop_count: got %0d expected %0d", obsVal.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
            checks++;
            if (obsVal[base + i] !== expQ[i] || obsLat[base + i] !== 1) begin
                errors++;
                $display("[TB] FAIL loop_sample%0d: got %h latency %0d expected %h latency 1", i, obsVal[base + i], obsLat[base + i], expQ[i]);
            end
        end
        checks++; if (sample_out !== expQ[expQ.size() - 1] || busy !== 1'b1) begin errors++; $display("[TB] FAIL loop_hold: got %h busy %b expected %h busy 1", sample_out, busy, expQ[expQ.size() - 1]); end
        doStop();
        loop_en = 1'b0;
        checks++; if (sample_out !== 8'h80 || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL loop_stop: got %h busy %b req %b expected 80 0 0", sample_out, busy, mem_req); end
        checks++; if (doneCnt !== baseDone) begin errors++; $display("[TB] FAIL loop_no_done: got %0d done pulses expected 0", doneCnt - baseDone); end
    endtask

    task automatic test_underrun();
        int base = obsVal.size();
        int baseDone = doneCnt;
        ackHold = 1'b1;
        doPlay(16'h0010, 16'h0012, 1'b0);
        cycles(3);
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_flag: got %b expected 1", underrun); end
        checks++; if (obsVal.size() !== base || sample_out !== 8'h80) begin errors++; $display("[TB] FAIL underrun_hold: got %0d samples out %h expected 0 samples out 80", obsVal.size() - base, sample_out); end
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL underrun_req: got req %b addr %h expected 1 0010", mem_req, mem_addr); end
        ackHold = 1'b0;
        cycles(4);
        repeat (4) tick();
        modelPlayback(16'h0010, 16'h0012, 1'b0, 4);
        checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL underrun_count: got %0d expected %0d", obsVal.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
            checks++;
            if (obsVal[base + i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL underrun_sample%0d: got %h expected %h", i, obsVal[base + i], expQ[i]);
            end
        end
        checks++; if (doneCnt - baseDone !== 1 || underrun !== 1'b1) begin errors++; $display("[TB] FAIL underrun_end: got done %0d underrun %b expected 1 1", doneCnt - baseDone, underrun); end
    endtask

    task automatic test_stop_fetch();
        int base = obsVal.size();
        ackHold = 1'b1;
        doPlay(16'h0040, 16'h0042, 1'b0);
        cycles(2);
        checks++; if (underrun !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("[TB] FAIL stop_pre: got underrun %b req %b expected 0 1", underrun, mem_req); end
        doStop();
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || sample_out !== 8'h80) begin errors++; $display("[TB] FAIL stop_now: got req %b busy %b out %h expected 0 0 80", mem_req, busy, sample_out); end
        forceAck = 1'b1;
        cycles(3);
        forceAck = 1'b0;
        cycles(2);
        tick();
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || obsVal.size() !== base) begin errors++; $display("[TB] FAIL stop_late_ack: got busy %b req %b samples %0d expected 0 0 0", busy, mem_req, obsVal.size() - base); end
        ackHold = 1'b0;
    endtask

    task automatic test_invalid_and_collisions();
        int base;
        int baseDone;
        bit sawActive = 1'b0;
        doPlay(16'h0020, 16'h001F, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || mem_req !== 1'b0) sawActive = 1'b1;
            @(negedge clk_27MHz);
        end
        checks++; if (sawActive !== 1'b0) begin errors++; $display("[TB] FAIL reversed_range: got active %b expected 0", sawActive); end
        start_addr = 16'h0010;
        end_addr   = 16'h0012;
        play = 1'b1;
        stop = 1'b1;
        @(negedge clk_27MHz);
        play = 1'b0;
        stop = 1'b0;
        cycles(2);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL play_stop_same: got busy %b req %b expected 0 0", busy, mem_req); end
        base = obsVal.size();
        baseDone = doneCnt;
        play = 1'b1;
        clk_22khz = 1'b1;
        lastRaiseCyc = cyc;
        @(negedge clk_27MHz);
        play = 1'b0;
        cycles(7);
        clk_22khz = 1'b0;
        cycles(8);
        checks++; if (busy !== 1'b1 || obsVal.size() !== base) begin errors++; $display("[TB] FAIL play_tick_same: got busy %b samples %0d expected 1 0", busy, obsVal.size() - base); end
        doPlay(16'h0040, 16'h0040, 1'b0);
        cycles(2);
        repeat (4) tick();
        modelPlayback(16'h0010, 16'h0012, 1'b0, 4);
        checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL busy_play_count: got %0d expected %0d", obsVal.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
            checks++;
            if (obsVal[base + i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL busy_play_sample%0d: got %h expected %h", i, obsVal[base + i], expQ[i]);
            end
        end
        checks++; if (doneCnt - baseDone !== 1) begin errors++; $display("[TB] FAIL busy_play_done: got %0d expected 1", doneCnt - baseDone); end
    endtask

    task automatic test_top_of_memory();
        int base = obsVal.size();
        int baseDone = doneCnt;
        doPlay(16'hFFFE, 16'hFFFF, 1'b0);
        cycles(6);
        repeat (3) tick();
        modelPlayback(32'h0000FFFE, 32'h0000FFFF, 1'b0, 3);
        checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL top_count: got %0d expected %0d", obsVal.size() - base, expQ.size()); end
        for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
            checks++;
            if (obsVal[base + i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL top_sample%0d: got %h expected %h", i, obsVal[base + i], expQ[i]);
            end
        end
        checks++; if (mem_addr !== 16'hFFFF || busy !== 1'b0 || doneCnt - baseDone !== 1) begin errors++; $display("[TB] FAIL top_end: got addr %h busy %b done %0d expected FFFF 0 1", mem_addr, busy, doneCnt - baseDone); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len = int'($urandom_range(1, 5));
            int s = int'($urandom_range(32'h40, 32'hF0));
            int e = s + len - 1;
            bit lp = 1'($urandom_range(0, 1));
            int nTicks = lp ? len + int'($urandom_range(1, 4)) : len + 1;
            int base = obsVal.size();
            int baseDone = doneCnt;
            ackDelay = int'($urandom_range(0, 3));
            doPlay(s[ADDR_W-1:0], e[ADDR_W-1:0], lp);
            cycles(6);
            repeat (nTicks) tick();
            modelPlayback(s, e, lp, nTicks);
            checks++; if (obsVal.size() - base !== expQ.size()) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", it, obsVal.size() - base, expQ.size()); end
            for (int i = 0; i < expQ.size() && base + i < obsVal.size(); i++) begin
                checks++;
                if (obsVal[base + i] !== expQ[i] || obsLat[base + i] !== 1) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_sample%0d: got %h latency %0d expected %h latency 1", it, i, obsVal[base + i], obsLat[base + i], expQ[i]);
                end
            end
            checks++; if (doneCnt - baseDone !== int'(expDone) || busy !== lp) begin errors++; $display("[TB] FAIL rand%0d_end: got done %0d busy %b expected %0d %b", it, doneCnt - baseDone, busy, int'(expDone), lp); end
            if (lp) doStop();
            loop_en = 1'b0;
        end
        ackDelay = 2;
    endtask

    task automatic test_reset_mid();
        ackDelay = 1;
        doPlay(16'h0010, 16'h0012, 1'b0);
        cycles(6);
        ackHold = 1'b1;
        tick();
        checks++; if (sample_out !== memArr[8'h10] || mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre: got out %h req %b expected %h 1", sample_out, mem_req, memArr[8'h10]); end
        reset = 1'b1;
        @(negedge clk_27MHz);
        checks++; if (sample_out !== 8'h80 || busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0000 || sample_valid !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_state: got out %h busy %b req %b addr %h valid %b underrun %b expected 80 0 0 0000 0 0", sample_out, busy, mem_req, mem_addr, sample_valid, underrun);
        end
        reset = 1'b0;
        ackHold = 1'b0;
        forceAck = 1'b1;
        cycles(2);
        forceAck = 1'b0;
        cycles(2);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ack: got busy %b req %b expected 0 0", busy, mem_req); end
        ackDelay = 2;
    endtask

    task automatic test_pwm();
        int highs = 0;
        int expHighs;
        int baseDone = doneCnt;
`ifdef AUDIO_PWM_OUT_EN
        expHighs = 64;
`else
        expHighs = 0;
`endif
        doPlay(16'h0030, 16'h0030, 1'b0);
        cycles(6);
        tick();
        checks++; if (sample_out !== 8'h40) begin errors++; $display("[TB] FAIL pwm_level: got %h expected 40", sample_out); end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_27MHz);
            if (pwm_out === 1'b1) highs++;
        end
        checks++; if (highs !== expHighs) begin errors++; $display("[TB] FAIL pwm_duty: got %0d high cycles expected %0d", highs, expHighs); end
        tick();
        checks++; if (doneCnt - baseDone !== 1 || sample_out !== 8'h80) begin errors++; $display("[TB] FAIL pwm_drain: got done %0d out %h expected 1 80", doneCnt - baseDone, sample_out); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = 8'($urandom);
        memArr[8'h10] = 8'h11;
        memArr[8'h11] = 8'h22;
        memArr[8'h12] = 8'h33;
        memArr[8'h30] = 8'h40;
        reset = 1'b1;
        repeat (3) @(negedge clk_27MHz);
        $display("[TB] starting audio_sample_player tests");
        test_reset();
        test_single_pass();
        test_loop();
        test_underrun();
        test_stop_fetch();
        test_invalid_and_collisions();
        test_top_of_memory();
        test_random();
        test_reset_mid();
        test_pwm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
